uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the processor data bus, downstream of the core's mem_* port.

---
 rtl/uart_tx_mmio_pkg.sv | 29 ++
 rtl/uart_tx_mmio_if.sv | 20 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 54 +++++
 rtl/uart_tx_mmio.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// transmitter states, register offsets, STATUS bit positions and divisor sanitising.
package uart_tx_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Word offsets within the 16-byte window (mem_addr[3:2]).
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  // STATUS register bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;

  // A zero divisor would stall the bit timer, so it is stored as 1.
  function automatic logic [15:0] fix_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core-side data bus as seen by a memory-mapped peripheral: one-cycle stores
// and loads with registered read data and a hit flag for the SoC read mux.
interface uart_tx_mmio_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_rstrb;
  logic [XLEN-1:0] io_rdata;
  logic            io_hit;

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  io_rdata, io_hit
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output io_rdata, io_hit
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: decodes a 16-byte bus window, queues
// stored bytes in a TX FIFO and shifts them out LSB first on tx.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0040_0000,
  parameter int              FIFO_DEPTH  = 8,
  parameter logic [15:0]     DEFAULT_DIV = 16'd217
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            sel;
  logic [1:0]      off;
  logic            store;
  logic            push;
  logic            pop;
  logic            ovf_clr;
  logic            div_wr;
  logic [15:0]     div;
  logic [15:0]     div_next;
  logic            ovf;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic [7:0]      fifo_dout;
  logic [XLEN-1:0] status;
  tx_state_t       state;
  logic [15:0]     cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_end;
  logic            busy;
  logic            unused_bits;

  assign sel      = (bus.mem_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign off      = bus.mem_addr[3:2];
  assign store    = sel && (bus.mem_wmask != 4'd0);
  assign push     = store && (off == REG_TXDATA) && bus.mem_wmask[0];
  assign ovf_clr  = store && (off == REG_STATUS) && bus.mem_wmask[0] && bus.mem_wdata[3];
  assign div_wr   = store && (off == REG_BAUDDIV) && (bus.mem_wmask[1:0] != 2'd0);
  assign div_next = fix_div({bus.mem_wmask[1] ? bus.mem_wdata[15:8] : div[15:8],
                             bus.mem_wmask[0] ? bus.mem_wdata[7:0]  : div[7:0]});
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[XLEN-1:16], bus.mem_wmask[3:2]};

  // Bit timer compares against the live divisor so a mid-bit write applies at once.
  assign bit_end = (cnt >= div - 16'd1);
  assign busy    = (state != ST_IDLE);
  assign pop     = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (bus.mem_wdata[7:0]),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // STATUS view of the state before any same-cycle push or pop.
  always_comb begin
    status                              = '0;
    status[STAT_BUSY]                   = busy;
    status[STAT_FULL]                   = fifo_full;
    status[STAT_EMPTY]                  = fifo_empty;
    status[STAT_OVF]                    = ovf;
    status[STAT_LVL_LSB +: 8]           = 8'(fifo_level);
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn)                           ovf <= 1'b0;
    else if (push && fifo_full && !pop)    ovf <= 1'b1;
    else if (ovf_clr)                      ovf <= 1'b0;
  end

  // Baud divisor with per-byte-lane writes.
  always_ff @(posedge clk) begin
    if (!resetn)     div <= DEFAULT_DIV;
    else if (div_wr) div <= div_next;
  end

  // Registered read port; hit and data hold until the next read strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.io_rdata <= '0;
      bus.io_hit   <= 1'b0;
    end else if (bus.mem_rstrb) begin
      bus.io_hit <= sel;
      if (sel) begin
        case (off)
          REG_STATUS:  bus.io_rdata <= status;
          REG_BAUDDIV: bus.io_rdata <= XLEN'(div);
          default:     bus.io_rdata <= '0;
        endcase
      end
    end
  end

  // Frame sequencer with inline bit timer and shifter; tx is registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (!fifo_empty) begin
            shift   <= fifo_dout;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= shift[0];
            shift <= shift >> 1;
            state <= ST_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!fifo_empty) begin
              shift   <= fifo_dout;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame waveforms,
// back-to-back frames, overflow handling and reset mid-frame.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tx;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_tx_mmio_if #(.XLEN(32)) bus ();

  uart_tx_mmio #(
    .XLEN        (32),
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd217)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_wmask = mask;
    @(negedge clk);
    bus.mem_wmask = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_rstrb = 1'b1;
    @(negedge clk);
    bus.mem_rstrb = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus_read(addr);
    check(tag, bus.io_rdata, exp);
    check({tag, "_hit"}, 32'(bus.io_hit), 32'd1);
  endtask

  // Expects start bit, 8 data bits LSB first, stop bit, each div cycles,
  // beginning two cycles after the first store is driven.
  task automatic watch_tx(input string tag, input int div, input int nbytes,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    logic       e;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    repeat (2) @(negedge clk);
    for (int k = 0; k < nbytes; k++) begin
      for (int bi = 0; bi < 10; bi++) begin
        if (bi == 0)      e = 1'b0;
        else if (bi == 9) e = 1'b1;
        else              e = bytes[k][bi-1];
        for (int c = 0; c < div; c++) begin
          @(negedge clk);
          check(tag, 32'(tx), 32'(e));
        end
      end
    end
  endtask

  initial begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = 4'd0;
    bus.mem_rstrb = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", bus.io_rdata, 32'd0);
    check("rst_hit", 32'(bus.io_hit), 32'd0);
    resetn = 1'b1;

    read_check("status_rst", BASE + 32'h4, 32'h0000_0004);
    read_check("bauddiv_rst", BASE + 32'h8, 32'd217);

    bus_read(32'h0000_0100);
    check("outside_hit", 32'(bus.io_hit), 32'd0);
    check("outside_rdata", bus.io_rdata, 32'd217);

    read_check("reg_c", BASE + 32'hC, 32'd0);
    bus_write(BASE + 32'h8, 32'h0000_0000, 4'b0011);
    read_check("div_zero", BASE + 32'h8, 32'd1);
    bus_write(BASE + 32'h8, 32'h0000_1234, 4'b0011);
    bus_write(BASE + 32'h8, 32'h0000_0056, 4'b0001);
    read_check("div_lane", BASE + 32'h8, 32'h0000_1256);

    // Single frame, 4 cycles per bit.
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    fork
      bus_write(BASE, 32'h0000_00A5, 4'b0001);
      watch_tx("frame_a5", 4, 1, 8'hA5, 8'h00, 8'h00);
    join
    check("a5_idle_tx", 32'(tx), 32'd1);
    read_check("a5_done", BASE + 32'h4, 32'h0000_0004);

    // Three frames with no idle gap, 2 cycles per bit.
    bus_write(BASE + 32'h8, 32'd2, 4'b0011);
    fork
      begin
        bus_write(BASE, 32'h0000_0001, 4'b0001);
        bus_write(BASE, 32'h0000_0080, 4'b0001);
        bus_write(BASE, 32'h0000_00FF, 4'b0001);
      end
      watch_tx("b2b", 2, 3, 8'h01, 8'h80, 8'hFF);
    join
    check("b2b_idle_tx", 32'(tx), 32'd1);
    read_check("b2b_done", BASE + 32'h4, 32'h0000_0004);

    // Overflow: one byte in flight, eight queued, one dropped.
    bus_write(BASE + 32'h8, 32'd1000, 4'b0011);
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'h0000_0000, 4'b0001);
    read_check("ovf_status", BASE + 32'h4, 32'h0000_080B);
    bus_write(BASE + 32'h4, 32'h0000_0008, 4'b0001);
    read_check("ovf_clear", BASE + 32'h4, 32'h0000_0803);

    // Reset in the middle of data bit 0 of the 0x00 frame.
    repeat (1500) @(negedge clk);
    check("mid_data_tx", 32'(tx), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_rdata", bus.io_rdata, 32'd0);
    check("rst_mid_hit", 32'(bus.io_hit), 32'd0);
    resetn = 1'b1;
    read_check("rst_mid_status", BASE + 32'h4, 32'h0000_0004);
    read_check("rst_mid_div", BASE + 32'h8, 32'd217);
    repeat (5) @(negedge clk);
    check("rst_mid_stay_idle", 32'(tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
